// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular exponentiation block.
// Holds the default prime width and the control FSM state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rsa_modexp_if.sv
// Request/result bus for rsa_modexp.
// master: drives in_valid/in_n/in_key/in_msg; slave: returns ready and result.
interface rsa_modexp_if #(
    parameter int WIDTH = rsa_pkg::RSA_WIDTH
);
    logic                 in_valid;
    logic [2*WIDTH-1:0]   in_n;
    logic [2*WIDTH-1:0]   in_key;
    logic [2*WIDTH-1:0]   in_msg;
    logic                 in_ready;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out_data;
    logic                 out_err;

    modport master (
        output in_valid, in_n, in_key, in_msg,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_n, in_key, in_msg,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rsa_modmul.sv
// Combinational modular multiply: p_o = a_i*b_i mod n_i, 0 when n_i < 2.
// Ports: a_i, b_i, n_i (KW bits) in; p_o (KW bits) out.
module rsa_modmul #(
    parameter int KW = 6
) (
    input  logic [KW-1:0] a_i,
    input  logic [KW-1:0] b_i,
    input  logic [KW-1:0] n_i,
    output logic [KW-1:0] p_o
);
    logic [2*KW-1:0] prod;
    logic [2*KW-1:0] rem;

    // Full double-width product, reduced only once.
    assign prod = {{KW{1'b0}}, a_i} * {{KW{1'b0}}, b_i};
    assign rem  = prod % {{KW{1'b0}}, n_i};
    assign p_o  = (n_i < KW'(2)) ? '0 : KW'(rem);
endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation, one key bit/cycle.
// Ports: clk, rst (async, active high), bus (rsa_modexp_if.slave).
// Optional input check flag (out_err) enabled by macro RSA_MODEXP_CHECK_EN.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input logic          clk,
    input logic          rst,
    rsa_modexp_if.slave  bus
);
    localparam int KW = 2 * WIDTH;
    localparam int CW = (KW > 1) ? $clog2(KW) : 1;

    state_t          state_q, state_d;
    logic [KW-1:0]   n_q, n_d;
    logic [KW-1:0]   key_q, key_d;
    logic [KW-1:0]   m_q, m_d;
    logic [KW-1:0]   r_q, r_d;
    logic [KW-1:0]   out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   sq, mul;
    logic            n_small;

    rsa_modmul #(.KW(KW)) u_sq (
        .a_i(r_q), .b_i(r_q), .n_i(n_q), .p_o(sq)
    );

    rsa_modmul #(.KW(KW)) u_mul (
        .a_i(sq), .b_i(m_q), .n_i(n_q), .p_o(mul)
    );

    assign n_small = (bus.in_n < KW'(2));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        key_d   = key_q;
        m_d     = m_q;
        r_d     = r_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CALC;
                    n_d     = bus.in_n;
                    key_d   = bus.in_key;
                    m_d     = n_small ? '0 : bus.in_msg % bus.in_n;
                    r_d     = n_small ? '0 : KW'(1);
                    cnt_d   = '0;
                end
            end
            CALC: begin
                // Key is shifted left so its MSB is always the current bit.
                r_d   = key_q[KW-1] ? mul : sq;
                key_d = key_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(KW - 1)) begin
                    state_d = DONE;
                    out_d   = r_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            key_q   <= '0;
            m_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            key_q   <= key_d;
            m_q     <= m_d;
            r_q     <= r_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;

`ifdef RSA_MODEXP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && bus.in_valid) begin
            err_d = n_small || (bus.in_msg >= bus.in_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.out_err = err_q && (state_q == DONE);
`else
    assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp (WIDTH=3): directed and random cases
// against an arithmetic reference model; honours RSA_MODEXP_CHECK_EN.
module tb_rsa_modexp;
    localparam int W  = 3;
    localparam int KW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rsa_modexp_if #(.WIDTH(W)) bus ();

    rsa_modexp #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_exp(int n, int k, int m);
        int r;
        int mm;
        if (n < 2) return 0;
        mm = m % n;
        r  = 1;
        for (int i = 0; i < k; i++) r = (r * mm) % n;
        return r;
    endfunction

    function automatic logic ref_err(int n, int m);
`ifdef RSA_MODEXP_CHECK_EN
        return (n < 2) || (m >= n);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(int n, int k, int m);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_n     = KW'(n);
        bus.in_key   = KW'(k);
        bus.in_msg   = KW'(m);
        guard = 0;
        while (!bus.in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // lat starts as the cycle offset from T of the current sample point.
    task automatic wait_res(string tag, int n, int k, int m, int lat0);
        int lat;
        lat = lat0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd7);
        check({tag, "_data"}, 32'(bus.out_data), 32'(ref_exp(n, k, m)));
        check({tag, "_err"}, 32'(bus.out_err), 32'(ref_err(n, m)));
    endtask

    task automatic run(string tag, int n, int k, int m);
        send(n, k, m);
        wait_res(tag, n, k, m, 1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_hold"}, 32'(bus.out_data), 32'(ref_exp(n, k, m)));
    endtask

    initial begin
        int pulses;
        int n, k, m;
        bus.in_valid = 1'b0;
        bus.in_n     = '0;
        bus.in_key   = '0;
        bus.in_msg   = '0;
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("enc15", 15, 3, 2);
        run("dec15", 15, 3, 8);

        // Overlapping request at T+3 must be ignored until T+8.
        send(35, 5, 3);
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_n     = KW'(35);
        bus.in_key   = KW'(5);
        bus.in_msg   = KW'(33);
        check("busy_ready", 32'(bus.in_ready), 32'd0);
        wait_res("enc35", 35, 5, 3, 3);
        @(negedge clk);
        check("t8_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_res("dec35", 35, 5, 33, 1);
        @(negedge clk);

        run("key0", 35, 0, 40);
        run("n1", 1, 5, 0);
        run("n0", 0, 7, 9);

        // Reset in the middle of a computation.
        send(15, 3, 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_data", 32'(bus.out_data), 32'd0);
        check("abort_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("abort_nopulse", 32'(pulses), 32'd0);

        // Accept in the first cycle after reset release.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        run("post_rst", 15, 3, 2);

        for (int i = 0; i < 24; i++) begin
            n = int'($urandom_range(0, 63));
            k = int'($urandom_range(0, 63));
            m = int'($urandom_range(0, 63));
            run($sformatf("rnd%0d", i), n, k, m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
